// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for a synchronous FIFO: issues reads against the empty
// flag, absorbs the one-cycle read latency and presents a 2-deep valid/ready stream.

module fifo_stream_reader_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       fifo_empty,
    input logic       fifo_r_en,
    input logic       flush,
    input logic [1:0] occ,
    input logic       inflight
);

    // Buffered words plus the outstanding read must always fit the 2-entry buffer.
    a_depth: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

    a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_r_en && fifo_empty));

    a_no_read_during_flush: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_r_en && flush));

endmodule

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    logic [DATA_WIDTH-1:0] mem_r [2];
    logic                  head_r;
    logic                  tail_r;
    logic [1:0]            occ_r;
    logic                  inflight_r;

    logic                  pop_s;
    logic                  capture_s;
    logic [2:0]            level_s;
    logic                  rd_en_s;
    logic [1:0]            occ_next_s;
    logic                  head_next_s;
    logic                  tail_next_s;
    logic [DATA_WIDTH-1:0] m_data_next_s;

    assign pop_s     = m_valid & m_ready;
    assign capture_s = inflight_r & ~flush;
    assign fifo_r_en = rd_en_s;

    // Read issue: the slot freed by a same-cycle pop may be refilled immediately.
    always_comb begin
        level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_en_s = rst_n & ~flush & ~fifo_empty & (level_s < 3'd2);
    end

    // Next occupancy and ring indices from capture/pop/flush.
    always_comb begin
        occ_next_s  = occ_r;
        head_next_s = head_r;
        tail_next_s = tail_r;
        if (flush) begin
            occ_next_s  = 2'd0;
            head_next_s = 1'b0;
            tail_next_s = 1'b0;
        end else begin
            case ({capture_s, pop_s})
                2'b10: begin
                    occ_next_s  = occ_r + 2'd1;
                    tail_next_s = ~tail_r;
                end
                2'b01: begin
                    occ_next_s  = occ_r - 2'd1;
                    head_next_s = ~head_r;
                end
                2'b11: begin
                    head_next_s = ~head_r;
                    tail_next_s = ~tail_r;
                end
                default: begin
                    occ_next_s = occ_r;
                end
            endcase
        end
    end

    // Next head word: bypass the returning read when it lands in the new head slot.
    always_comb begin
        if (capture_s && (tail_r == head_next_s)) begin
            m_data_next_s = fifo_data;
        end else begin
            m_data_next_s = mem_r[head_next_s];
        end
    end

    // Buffer storage written at the tail on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {DATA_WIDTH{1'b0}};
            mem_r[1] <= {DATA_WIDTH{1'b0}};
        end else if (capture_s) begin
            mem_r[tail_r] <= fifo_data;
        end
    end

    // Control state: occupancy, indices and the outstanding-read flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r      <= 2'd0;
            head_r     <= 1'b0;
            tail_r     <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            occ_r      <= occ_next_s;
            head_r     <= head_next_s;
            tail_r     <= tail_next_s;
            inflight_r <= rd_en_s & ~flush;
        end
    end

    // Registered stream outputs, kept in step with the buffer head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            m_valid <= (occ_next_s != 2'd0);
            m_data  <= m_data_next_s;
        end
    end

    // Completed-handshake counter; a pop coincident with flush still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= {CNT_WIDTH{1'b0}};
        end else if (pop_s) begin
            xfer_count <= xfer_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    fifo_stream_reader_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (rd_en_s),
        .flush      (flush),
        .occ        (occ_r),
        .inflight   (inflight_r)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural registered-read FIFO.

module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_r_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        flush;
    logic [15:0] xfer_count;

    logic        w_r_en;
    logic        w_m_valid;
    logic [7:0]  w_m_data;
    logic [3:0]  w_xfer_count;

    logic [7:0]  src [128];
    int          src_len;
    int          rd_idx = 0;
    logic [7:0]  exp_q [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .flush(flush), .xfer_count(xfer_count)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_r_en(w_r_en), .m_valid(w_m_valid), .m_data(w_m_data), .m_ready(m_ready),
        .flush(flush), .xfer_count(w_xfer_count)
    );

    assign fifo_empty = (rd_idx == src_len);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v, input bit expect_out);
        src[src_len] = v;
        src_len = src_len + 1;
        if (expect_out) exp_q.push_back(v);
    endtask

    // FIFO model: data_out updates on the edge that samples a read of a non-empty FIFO.
    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data <= src[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    // Monitor: pop the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("r_en_while_empty", {31'd0, fifo_r_en & fifo_empty}, 32'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h expected none", m_data);
                end else begin
                    chk("pop_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int start;
        rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0; src_len = 0;

        // Reset state, with the FIFO already preloaded
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) load(8'h11 + 8'(i), 1'b1);
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
        chk("rst_r_en", {31'd0, fifo_r_en}, 32'd0);

        // Stream after reset
        step();
        rst_n = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        chk("s1_r_en_first", {31'd0, fifo_r_en}, 32'd1);
        chk("s1_valid_n0", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        chk("s1_valid_n1", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s1_valid_run", {31'd0, m_valid}, 32'd1);
        end
        chk("s1_r_en_drained", {31'd0, fifo_r_en}, 32'd0);
        @(negedge clk);
        chk("s1_xfer", {16'd0, xfer_count}, 32'd5);
        chk("s1_valid_end", {31'd0, m_valid}, 32'd0);

        // Backpressure
        step();
        m_ready = 1'b0;
        start = rd_idx;
        for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i), 1'b1);
        repeat (10) @(negedge clk);
        chk("bp_reads", 32'(rd_idx - start), 32'd2);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_hold_data", {24'd0, m_data}, 32'hA0);
        chk("bp_r_en_off", {31'd0, fifo_r_en}, 32'd0);
        step();
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_r_en_resume", {31'd0, fifo_r_en}, 32'd1);
        chk("bp_valid_r0", {31'd0, m_valid}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("bp_no_gap", {31'd0, m_valid}, 32'd1);
        end
        @(negedge clk);
        chk("bp_valid_end", {31'd0, m_valid}, 32'd0);
        chk("bp_xfer", {16'd0, xfer_count}, 32'd13);

        // Alternating ready
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i), 1'b1);
        for (int i = 0; i < 30; i++) begin
            step();
            m_ready = ~m_ready;
        end
        @(negedge clk);
        chk("alt_xfer", {16'd0, xfer_count}, 32'd21);
        chk("alt_valid_end", {31'd0, m_valid}, 32'd0);

        // Flush while one word is buffered and one read is in flight
        step();
        m_ready = 1'b0;
        load(8'h50, 1'b0);
        load(8'h51, 1'b0);
        load(8'h52, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("fl_valid_pre", {31'd0, m_valid}, 32'd0);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_valid_occ1", {31'd0, m_valid}, 32'd1);
        chk("fl_r_en_held", {31'd0, fifo_r_en}, 32'd0);
        step();
        flush = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("fl_valid_after", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("fl_next_valid", {31'd0, m_valid}, 32'd1);
        @(negedge clk);
        chk("fl_xfer", {16'd0, xfer_count}, 32'd22);

        // Asynchronous reset between edges while m_valid=1
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'h60 + 8'(i), 1'b0);
        repeat (3) @(negedge clk);
        chk("ar_valid_pre", {31'd0, m_valid}, 32'd1);
        chk("ar_data_pre", {24'd0, m_data}, 32'h60);
        step();
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, m_valid}, 32'd0);
        chk("ar_data", {24'd0, m_data}, 32'd0);
        chk("ar_xfer", {16'd0, xfer_count}, 32'd0);
        chk("ar_r_en", {31'd0, fifo_r_en}, 32'd0);
        src_len = rd_idx;
        step();
        rst_n = 1'b1;

        // Counter wrap on the 4-bit instance: 17 pops
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) load(8'h70 + 8'(i), 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("wr_valid", {31'd0, w_m_valid}, 32'd1);
            chk("wr_data", {24'd0, w_m_data}, 32'h70 + 32'(i));
        end
        @(negedge clk);
        chk("wr_xfer4", {28'd0, w_xfer_count}, 32'd1);
        chk("wr_xfer16", {16'd0, xfer_count}, 32'd17);
        chk("wr_r_en_idle", {31'd0, w_r_en}, 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
